packet_stats: RTL and testbench
===============================

PACKET_STATS -- requirements
Module: packet_stats

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NSINK, 4, packets per run (channel count).
- WIDTH, 16, sample width, Q<WIDTH>.0.
- LENGTH, 256, samples per packet.
REQ-002 Derived localparams SHALL be AWIDTH = $clog2(LENGTH), BWIDTH = $clog2(NSINK), SWIDTH = WIDTH+AWIDTH.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; connects to the upstream source_clk.
- reset, input, 1, synchronous reset, active-high.
- sink_valid, input, 1, input sample valid.
- sink_sop, input, 1, first sample of packet.
- sink_eop, input, 1, last sample of packet.
- sink_data, input, WIDTH, sample, Q<WIDTH>.0 signed.
- source_valid, output, 1, one-cycle result strobe.
- source_channel, output, BWIDTH, packet index within run.
- source_sum, output, SWIDTH, packet sum, Q<SWIDTH>.0 signed.
- source_max, output, WIDTH, packet peak value.
- source_argmax, output, AWIDTH, sample index of the peak.
- source_error, output, 1, length or framing error in this packet.
REQ-004 The block has one clock; reset is synchronous and active-high.

Function
REQ-005 The FSM SHALL have states IDLE and ACC. Only sink_valid-qualified beats count; all other sink inputs are ignored when sink_valid=0.
REQ-006 In IDLE, a beat with sop=1 SHALL:
- load sum=data, max=data, argmax=0, idx=1;
- clear the error flag;
- move to ACC, or complete the packet immediately if eop=1 on the same beat.
REQ-007 In IDLE, a beat with sop=0 SHALL be discarded, with no output and no state change.
REQ-008 In ACC, each beat SHALL:
- add data to sum (sign-extended);
- replace max and argmax only if data > max strictly, so the first occurrence wins ties;
- increment idx.
REQ-009 In ACC, a beat with sop=1 SHALL:
- abort the current packet, with no output and no channel increment;
- restart accumulation from that beat as in REQ-006.
REQ-010 Packet completion (eop beat) SHALL:
- pulse source_valid exactly one cycle after the eop beat;
- present sum, max and argmax including the eop sample;
- set source_error=1 if the sample count differs from LENGTH;
- return the FSM to IDLE.
REQ-011 If idx reaches LENGTH without an eop, the next beat SHALL set the error flag. Accumulation continues, and idx saturates at LENGTH-1.
REQ-012 source_channel SHALL equal a packet counter that starts at 0 and increments after each completed packet. It SHALL wrap from NSINK-1 to 0, with error packets included.
REQ-013 Result outputs SHALL hold their values between strobes.
REQ-014 Throughput SHALL be one beat per clock with no backpressure. Back-to-back packets (eop on cycle n, sop on cycle n+1) SHALL be processed without loss.

Reset
REQ-015 While reset=1, the block SHALL:
- force FSM=IDLE, source_valid=0, source_channel=0, source_error=0;
- clear source_sum, source_max, source_argmax and the internal accumulators to 0.
REQ-016 Reset during ACC SHALL drop the partial packet silently, and reset SHALL override every simultaneous sink beat.

Configuration
REQ-017 With macro PACKET_STATS_ABS_EN defined, peak comparison SHALL use |data|. The magnitude is saturated, so -2^(WIDTH-1) maps to 2^(WIDTH-1)-1, and source_max reports that magnitude.
REQ-018 Without PACKET_STATS_ABS_EN, peak comparison SHALL use signed data directly. source_sum is unaffected in both cases.

Structure
REQ-019 A shared package packet_stats_pkg SHALL hold the state enum type (IDLE, ACC) and a function for the SWIDTH computation.
REQ-020 One sub-module abs_sat SHALL implement the saturating absolute value. It SHALL be instantiated only under PACKET_STATS_ABS_EN.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- WIDTH=16, LENGTH=4, data 3,-1,7,7 -> sum=16, max=7, argmax=2, error=0, valid one cycle after eop.
- NSINK=4, six clean packets -> channel sequence 0,1,2,3,0,1.
- sop at idx 2 of a packet, then a clean 4-sample packet -> one result only, from the second packet, channel 0.
- eop after 3 samples (LENGTH=4) -> error=1 and sum of 3 samples; the following clean packet has error=0.
- ABS_EN, data -32768,5,-3,2 -> max=32767, argmax=0; without ABS_EN -> max=5, argmax=1.
- Reset asserted mid-packet, then a clean packet -> no stale output, channel 0, correct sum.

Source files
------------

// File: rtl/packet_stats_pkg.sv
// rtl/packet_stats_pkg.sv - shared FSM state type and width helper for packet_stats
package packet_stats_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Sum width: sample width plus enough headroom for LENGTH additions.
    function automatic int calc_swidth(input int width, input int length);
        return width + $clog2(length);
    endfunction

endpackage

// File: rtl/packet_stats_abs_sat.sv
// rtl/packet_stats_abs_sat.sv - saturating absolute value of a signed sample
module abs_sat #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] mag
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // The most negative value has no positive twin, so clamp it.
    always_comb begin
        if (data == MOST_NEG)
            mag = MOST_POS;
        else if (data[WIDTH-1])
            mag = -data;
        else
            mag = data;
    end

endmodule

// File: rtl/packet_stats.sv
// rtl/packet_stats.sv - per-packet sum/peak/argmax with length check; PACKET_STATS_ABS_EN selects |data| peaks
module packet_stats
    import packet_stats_pkg::*;
#(
    parameter int NSINK  = 4,
    parameter int WIDTH  = 16,
    parameter int LENGTH = 256,
    localparam int AWIDTH = $clog2(LENGTH),
    localparam int BWIDTH = $clog2(NSINK),
    localparam int SWIDTH = calc_swidth(WIDTH, LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sink_valid,
    input  logic              sink_sop,
    input  logic              sink_eop,
    input  logic [WIDTH-1:0]  sink_data,
    output logic              source_valid,
    output logic [BWIDTH-1:0] source_channel,
    output logic [SWIDTH-1:0] source_sum,
    output logic [WIDTH-1:0]  source_max,
    output logic [AWIDTH-1:0] source_argmax,
    output logic              source_error
);

    state_t                   state, state_n;
    logic signed [SWIDTH-1:0] sum, sum_n;
    logic signed [WIDTH-1:0]  pk_max, pk_max_n, peak;
    logic [AWIDTH-1:0]        argmax, argmax_n, idx, idx_n, cur_idx;
    logic                     err, err_n, full, full_n;
    logic                     start, accept, at_last, done, pkt_err;
    logic [BWIDTH-1:0]        chan;

`ifdef PACKET_STATS_ABS_EN
    logic [WIDTH-1:0] mag;

    abs_sat #(.WIDTH(WIDTH)) u_abs_sat (
        .data (sink_data),
        .mag  (mag)
    );

    assign peak = $signed(mag);
`else
    assign peak = $signed(sink_data);
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    // full marks that LENGTH samples are already in; any further beat is an overrun.
    always_comb begin
        state_n  = state;
        sum_n    = sum;
        pk_max_n = pk_max;
        argmax_n = argmax;
        idx_n    = idx;
        err_n    = err;
        full_n   = full;
        pkt_err  = 1'b0;
        start    = sink_valid && sink_sop;
        accept   = start || (sink_valid && state == ACC);
        cur_idx  = start ? '0 : idx;
        at_last  = (cur_idx == AWIDTH'(LENGTH - 1));
        done     = accept && sink_eop;
        if (accept) begin
            sum_n  = (start ? '0 : sum) + SWIDTH'($signed(sink_data));
            err_n  = start ? 1'b0 : (err | full);
            full_n = (start ? 1'b0 : full) | at_last;
            idx_n  = at_last ? cur_idx : cur_idx + 1'b1;
            if (start || peak > pk_max) begin
                pk_max_n = peak;
                argmax_n = cur_idx;
            end
            pkt_err = err_n | !at_last;
            state_n = sink_eop ? IDLE : ACC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum            <= '0;
            pk_max         <= '0;
            argmax         <= '0;
            idx            <= '0;
            err            <= 1'b0;
            full           <= 1'b0;
            chan           <= '0;
            source_valid   <= 1'b0;
            source_channel <= '0;
            source_sum     <= '0;
            source_max     <= '0;
            source_argmax  <= '0;
            source_error   <= 1'b0;
        end else begin
            sum          <= sum_n;
            pk_max       <= pk_max_n;
            argmax       <= argmax_n;
            idx          <= idx_n;
            err          <= err_n;
            full         <= full_n;
            source_valid <= done;
            if (done) begin
                source_channel <= chan;
                source_sum     <= sum_n;
                source_max     <= pk_max_n;
                source_argmax  <= argmax_n;
                source_error   <= pkt_err;
                chan           <= (chan == BWIDTH'(NSINK - 1)) ? '0 : chan + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packet_stats.sv
// tb/tb_packet_stats.sv - directed self-checking bench for packet_stats (NSINK=4, WIDTH=16, LENGTH=4)
module tb_packet_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic        sink_valid, sink_sop, sink_eop;
    logic [15:0] sink_data;
    logic        source_valid;
    logic [1:0]  source_channel;
    logic [17:0] source_sum;
    logic [15:0] source_max;
    logic [1:0]  source_argmax;
    logic        source_error;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [1:0]         ch;
        logic signed [17:0] sum;
        logic signed [15:0] mx;
        logic [1:0]         am;
        logic               err;
    } res_t;
    res_t res_q[$];

    packet_stats #(.NSINK(4), .WIDTH(16), .LENGTH(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .sink_valid     (sink_valid),
        .sink_sop       (sink_sop),
        .sink_eop       (sink_eop),
        .sink_data      (sink_data),
        .source_valid   (source_valid),
        .source_channel (source_channel),
        .source_sum     (source_sum),
        .source_max     (source_max),
        .source_argmax  (source_argmax),
        .source_error   (source_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (source_valid)
            res_q.push_back('{source_channel, $signed(source_sum), $signed(source_max),
                              source_argmax, source_error});
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        if (obs !== exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic s, input logic e, input logic [15:0] d);
        @(negedge clk);
        sink_valid = 1'b1;
        sink_sop   = s;
        sink_eop   = e;
        sink_data  = d;
    endtask

    // Idle cycles keep sop/eop high with valid low: they must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sink_valid = 1'b0;
            sink_sop   = 1'b1;
            sink_eop   = 1'b1;
            sink_data  = 16'h7fff;
        end
    endtask

    task automatic send4(input logic [15:0] a, b, c, d);
        beat(1'b1, 1'b0, a);
        beat(1'b0, 1'b0, b);
        beat(1'b0, 1'b0, c);
        beat(1'b0, 1'b1, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        res_q.delete();
    endtask

    task automatic expect_pkt(input string tag, input int ch, input longint sum,
                              input longint mx, input int am, input int err);
        res_t r;
        if (res_q.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            r = res_q.pop_front();
            check({tag, "_ch"},  r.ch,  ch);
            check({tag, "_sum"}, r.sum, sum);
            check({tag, "_max"}, r.mx,  mx);
            check({tag, "_am"},  r.am,  am);
            check({tag, "_err"}, r.err, err);
        end
    endtask

    initial begin
        reset = 1'b1;
        sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_data = '0;
        idle(3);
        check("rst_valid", source_valid, 0);
        check("rst_ch",    source_channel, 0);
        check("rst_sum",   source_sum, 0);
        check("rst_max",   source_max, 0);
        check("rst_am",    source_argmax, 0);
        check("rst_err",   source_error, 0);
        reset = 1'b0;
        idle(2);

        // Basic packet with strobe timing
        beat(1'b1, 1'b0, 16'd3);
        beat(1'b0, 1'b0, -16'sd1);
        beat(1'b0, 1'b0, 16'd7);
        beat(1'b0, 1'b1, 16'd7);
        check("s1_valid_before", source_valid, 0);
        idle(1);
        check("s1_valid_at", source_valid, 1);
        idle(1);
        check("s1_valid_after", source_valid, 0);
        idle(2);
        check("s1_hold_sum", source_sum, 16);
        expect_pkt("s1", 0, 16, 7, 2, 0);
        check("s1_count", res_q.size(), 0);

        // Six back-to-back packets: channel wrap
        do_reset();
        for (int k = 1; k <= 6; k++)
            send4(16'(k), 16'(-k), 16'(2 * k), 16'd1);
        idle(3);
        check("s2_count", res_q.size(), 6);
        for (int k = 1; k <= 6; k++)
            expect_pkt($sformatf("s2_p%0d", k), (k - 1) % 4, 2 * k + 1, 2 * k, 2, 0);

        // sop inside a packet aborts it
        do_reset();
        beat(1'b1, 1'b0, 16'd10);
        beat(1'b0, 1'b0, 16'd20);
        send4(16'd1, 16'd2, 16'd3, 16'd4);
        idle(3);
        check("s3_count", res_q.size(), 1);
        expect_pkt("s3", 0, 10, 4, 3, 0);

        // Short, clean, long packets
        beat(1'b1, 1'b0, 16'd5);
        beat(1'b0, 1'b0, 16'd6);
        beat(1'b0, 1'b1, 16'd7);
        send4(16'd1, 16'd1, 16'd1, 16'd1);
        beat(1'b1, 1'b0, 16'd1);
        beat(1'b0, 1'b0, 16'd2);
        beat(1'b0, 1'b0, 16'd3);
        beat(1'b0, 1'b0, 16'd4);
        beat(1'b0, 1'b1, 16'd5);
        idle(3);
        check("s4_count", res_q.size(), 3);
        expect_pkt("s4_short", 1, 18, 7, 2, 1);
        expect_pkt("s4_clean", 2, 4, 1, 0, 0);
        expect_pkt("s4_long",  3, 15, 5, 3, 1);

        // Peak mode
        send4(16'h8000, 16'd5, -16'sd3, 16'd2);
        idle(3);
`ifdef PACKET_STATS_ABS_EN
        expect_pkt("s5_abs", 0, -32764, 32767, 0, 0);
`else
        expect_pkt("s5_sgn", 0, -32764, 5, 1, 0);
`endif

        // Reset mid-packet overrides a simultaneous beat
        beat(1'b1, 1'b0, 16'd100);
        beat(1'b0, 1'b0, 16'd200);
        beat(1'b1, 1'b1, 16'd50);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        sink_valid = 1'b0;
        reset = 1'b0;
        check("s6_rst_count", res_q.size(), 0);
        check("s6_rst_ch", source_channel, 0);
        send4(16'd1, 16'd2, 16'd3, 16'd4);
        idle(3);
        check("s6_count", res_q.size(), 1);
        expect_pkt("s6", 0, 10, 4, 3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
